// File: rtl/sync_ram_dp.sv
// Simple-dual-port synchronous RAM with per-byte write enables, 1- or 2-cycle read
// latency, selectable read-during-write behaviour and a post-reset clear engine.
//
// Ports:
//   clk      - single clock, all state updates on the rising edge
//   rst_n    - asynchronous active-low reset
//   Din      - write data
//   waddr    - write address
//   writeEn  - write request
//   byteEn   - byte lane enables, bit k covers Din[8k+7:8k]
//   raddr    - read address
//   read     - read request
//   Dout     - read data, held between reads
//   Dvalid   - one-cycle pulse marking Dout as fresh read data
//   ready    - array usable (low in reset and while clearing)
module sync_ram_dp #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned RDW_MODE       = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   Din,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic                    writeEn,
    input  logic [DATA_WIDTH/8-1:0] byteEn,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    input  logic                    read,
    output logic [DATA_WIDTH-1:0]   Dout,
    output logic                    Dvalid,
    output logic                    ready
);

    localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

    if ((DATA_WIDTH % 8) != 0) begin : g_width_check
        $error("sync_ram_dp: DATA_WIDTH must be a multiple of 8");
    end

    typedef enum logic [1:0] {StReset, StClear, StReady} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    clr_last;
    logic                    clr_we;

    logic                    wr_fire;
    logic                    rd_fire;
    logic [NUM_BYTES-1:0]    mem_be;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic [DATA_WIDTH-1:0]   mem_q [RAM_DEPTH];

    logic [DATA_WIDTH-1:0]   pipe_q, pipe_d;
    logic                    pipe_vld_q, pipe_vld_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    dvalid_q, dvalid_d;

    assign clr_last = (clr_cnt_q == {ADDR_WIDTH{1'b1}});
    assign ready    = (state_q == StReady);
    assign wr_fire  = ready & writeEn;
    assign rd_fire  = ready & read;

    // The first edge after reset release already clears address 0, so the whole
    // array is zeroed in exactly RAM_DEPTH edges and ready rises on the last one.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        unique case (state_q)
            StReset, StClear: begin
                if (CLEAR_ON_RESET != 0) begin
                    clr_we = rst_n;
                    if (clr_last) begin
                        state_d = StReady;
                    end else begin
                        state_d   = StClear;
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = StReady;
                end
            end
            StReady: ;
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StReset;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Single array write port shared between the clear engine and the user.
    always_comb begin
        mem_be    = '0;
        mem_waddr = waddr;
        mem_wdata = Din;
        if (clr_we) begin
            mem_be    = '1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
        end else if (wr_fire) begin
            mem_be = byteEn;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (mem_be[k]) begin
                mem_q[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
    end

    // Array read returns the pre-write word; write-first mode merges enabled lanes.
    always_comb begin
        rd_word = mem_q[raddr];
        if ((RDW_MODE != 0) && wr_fire && (waddr == raddr)) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (byteEn[k]) begin
                    rd_word[8*k +: 8] = Din[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        pipe_d     = pipe_q;
        pipe_vld_d = rd_fire;
        if (rd_fire) begin
            pipe_d = rd_word;
        end
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        if (OUT_REG != 0) begin
            dvalid_d = pipe_vld_q;
            if (pipe_vld_q) begin
                dout_d = pipe_q;
            end
        end else begin
            dvalid_d = rd_fire;
            if (rd_fire) begin
                dout_d = rd_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q     <= '0;
            pipe_vld_q <= 1'b0;
            dout_q     <= '0;
            dvalid_q   <= 1'b0;
        end else begin
            pipe_q     <= pipe_d;
            pipe_vld_q <= pipe_vld_d;
            dout_q     <= dout_d;
            dvalid_q   <= dvalid_d;
        end
    end

    assign Dout   = dout_q;
    assign Dvalid = dvalid_q;

endmodule

// File: tb/tb_sync_ram_dp.sv
// Bench for sync_ram_dp: two instances share all stimulus, one with 1-cycle latency and
// read-first behaviour (a), one with the output register and write-first behaviour (b).
module tb_sync_ram_dp;

    logic        clk;
    logic        rst_n;
    logic [31:0] din;
    logic [3:0]  waddr;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  raddr;
    logic        rd;

    logic [31:0] a_dout, b_dout;
    logic        a_dv, b_dv, a_rdy, b_rdy;

    int total = 0;
    int bad   = 0;

    sync_ram_dp #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .Din(din), .waddr(waddr), .writeEn(we), .byteEn(be),
        .raddr(raddr), .read(rd), .Dout(a_dout), .Dvalid(a_dv), .ready(a_rdy)
    );

    sync_ram_dp #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .Din(din), .waddr(waddr), .writeEn(we), .byteEn(be),
        .raddr(raddr), .read(rd), .Dout(b_dout), .Dvalid(b_dv), .ready(b_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] din;
        logic [3:0]  be;
        logic        rd;
        logic [3:0]  ra;
        logic [31:0] a_dout;
        logic        a_dv;
        logic [31:0] b_dout;
        logic        b_dv;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; rd = 1'b0; be = 4'h0; din = '0; waddr = '0; raddr = '0;
    endtask

    function automatic logic [31:0] sweep_val(input int mode, input int i);
        return (mode != 0) ? 32'(2 * i + 1) : 32'h0;
    endfunction

    // Runs n clear edges from reset release; optionally pokes the user port late in the clear.
    task automatic run_clear(input int n, input bit poke);
        for (int k = 0; k < n; k++) begin
            if (poke && k >= 10 && k <= 12) begin
                we = 1'b1; waddr = 4'd2; din = 32'hFFFF_FFFF; be = 4'hF;
                rd = 1'b1; raddr = 4'd2;
            end else begin
                idle_inputs();
            end
            step();
            check("a_ready_clear", 32'(a_rdy), 32'(k == 15));
            check("b_ready_clear", 32'(b_rdy), 32'(k == 15));
            check("a_dvalid_clear", 32'(a_dv), 32'h0);
            check("b_dvalid_clear", 32'(b_dv), 32'h0);
        end
        idle_inputs();
    endtask

    task automatic read_all(input int mode);
        for (int i = 0; i < 16; i++) begin
            rd = 1'b1; raddr = 4'(i);
            step();
            check("a_dout_sweep", a_dout, sweep_val(mode, i));
            check("a_dv_sweep", 32'(a_dv), 32'h1);
            check("b_dv_sweep", 32'(b_dv), 32'(i > 0));
            if (i > 0) check("b_dout_sweep", b_dout, sweep_val(mode, i - 1));
        end
        rd = 1'b0;
        step();
        check("a_dv_tail", 32'(a_dv), 32'h0);
        check("a_dout_hold", a_dout, sweep_val(mode, 15));
        check("b_dv_tail", 32'(b_dv), 32'h1);
        check("b_dout_tail", b_dout, sweep_val(mode, 15));
        step();
        check("b_dv_tail2", 32'(b_dv), 32'h0);
        check("b_dout_hold", b_dout, sweep_val(mode, 15));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_dout"}, a_dout, 32'h0);
        check({tag, "_a_dv"}, 32'(a_dv), 32'h0);
        check({tag, "_a_ready"}, 32'(a_rdy), 32'h0);
        check({tag, "_b_dout"}, b_dout, 32'h0);
        check({tag, "_b_dv"}, 32'(b_dv), 32'h0);
        check({tag, "_b_ready"}, 32'(b_rdy), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected outputs after each edge; memory holds 2i+1 at address i beforehand.
        vecs[0]  = '{1'b1, 4'd3, 32'hAABBCCDD, 4'hF, 1'b0, 4'd0,
                     32'd31, 1'b0, 32'd31, 1'b0};
        vecs[1]  = '{1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, 4'd0,
                     32'd31, 1'b0, 32'd31, 1'b0};
        vecs[2]  = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3,
                     32'hAA22CC44, 1'b1, 32'd31, 1'b0};
        vecs[3]  = '{1'b1, 4'd5, 32'h0000000B, 4'hF, 1'b0, 4'd0,
                     32'hAA22CC44, 1'b0, 32'hAA22CC44, 1'b1};
        vecs[4]  = '{1'b1, 4'd5, 32'h12345678, 4'hF, 1'b1, 4'd5,
                     32'h0000000B, 1'b1, 32'hAA22CC44, 1'b0};
        vecs[5]  = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5,
                     32'h12345678, 1'b1, 32'h12345678, 1'b1};
        vecs[6]  = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0,
                     32'h12345678, 1'b0, 32'h12345678, 1'b1};
        vecs[7]  = '{1'b1, 4'd6, 32'hFFFFFFFF, 4'b0010, 1'b1, 4'd6,
                     32'h0000000D, 1'b1, 32'h12345678, 1'b0};
        vecs[8]  = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0,
                     32'h0000000D, 1'b0, 32'h0000FF0D, 1'b1};
        vecs[9]  = '{1'b1, 4'd7, 32'hCAFEF00D, 4'hF, 1'b1, 4'd8,
                     32'h00000011, 1'b1, 32'h0000FF0D, 1'b0};
        vecs[10] = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7,
                     32'hCAFEF00D, 1'b1, 32'h00000011, 1'b1};
        vecs[11] = '{1'b1, 4'd7, 32'h0, 4'h0, 1'b1, 4'd6,
                     32'h0000FF0D, 1'b1, 32'hCAFEF00D, 1'b1};
        vecs[12] = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7,
                     32'hCAFEF00D, 1'b1, 32'h0000FF0D, 1'b1};
        vecs[13] = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0,
                     32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b1};
        vecs[14] = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0,
                     32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0};

        rst_n = 1'b0;
        idle_inputs();
        repeat (3) step();
        check_reset_outputs("reset");

        // Clear after power-up, with ignored accesses to address 2 late in the clear.
        rst_n = 1'b1;
        run_clear(16, 1'b1);
        read_all(0);

        // Fill and read back.
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; waddr = 4'(i); din = 32'(2 * i + 1); be = 4'hF;
            step();
            check("a_dv_write", 32'(a_dv), 32'h0);
        end
        idle_inputs();
        read_all(1);

        // Byte enables, read-during-write and independent ports.
        for (int v = 0; v < 15; v++) begin
            we = vecs[v].we; waddr = vecs[v].wa; din = vecs[v].din; be = vecs[v].be;
            rd = vecs[v].rd; raddr = vecs[v].ra;
            step();
            check($sformatf("vec%0d_a_dout", v), a_dout, vecs[v].a_dout);
            check($sformatf("vec%0d_a_dv", v), 32'(a_dv), 32'(vecs[v].a_dv));
            check($sformatf("vec%0d_b_dout", v), b_dout, vecs[v].b_dout);
            check($sformatf("vec%0d_b_dv", v), 32'(b_dv), 32'(vecs[v].b_dv));
        end
        idle_inputs();

        // Asynchronous reset while b still has a read in its output pipeline.
        rd = 1'b1; raddr = 4'd3;
        step();
        check("pre_reset_a_dout", a_dout, 32'hAA22CC44);
        rd = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (3) step();
        rst_n = 1'b1;

        // Abort the clear halfway, then a full clear must run again from address 0.
        run_clear(8, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midclear_reset");
        repeat (2) step();
        rst_n = 1'b1;
        run_clear(16, 1'b1);
        read_all(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_ram_dp.md
# sync_ram_dp

Parametrised simple-dual-port synchronous RAM, the next generation of the team's single-port `sync_ram`. It has:
- independent write and read ports with configurable data width and depth;
- per-byte write enables;
- selectable read latency (1 or 2 cycles), with a `Dvalid` strobe;
- a configurable read-during-write policy;
- a built-in clear engine that zeroes the array after reset.

It serves as the generic data/instruction memory for the datapath blocks.

## Interface
- `DATA_WIDTH`, default 32: word width in bits; must be a multiple of 8 (elaboration-time `$error` otherwise).
- `ADDR_WIDTH`, default 10: address width; `RAM_DEPTH = 1 << ADDR_WIDTH` words.
- `OUT_REG`, default 0: 0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles.
- `RDW_MODE`, default 0: same-address read during write. 0 = read-first (old data); 1 = write-first (new merged data).
- `CLEAR_ON_RESET`, default 1: 1 = zero the whole array after reset; 0 = no clear.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Din` in DATA_WIDTH: write data.
- `waddr` in ADDR_WIDTH: write address.
- `writeEn` in 1: write request, sampled at the rising edge.
- `byteEn` in DATA_WIDTH/8: byte lane enables; bit k covers `Din[8k+7:8k]`.
- `raddr` in ADDR_WIDTH: read address.
- `read` in 1: read request, sampled at the rising edge.
- `Dout` out DATA_WIDTH: read data; holds its value between reads.
- `Dvalid` out 1: one-cycle pulse, `Dout` carries the data of an accepted read.
- `ready` out 1: 1 = array usable; 0 = in reset or clearing.

## Operation
- States:
  - `RESET`: while `rst_n`=0.
  - `CLEAR`: the clear engine is running.
  - `READY`: normal operation.
- Transitions:
  - `RESET` → `CLEAR` at the first rising edge after `rst_n` deasserts (`CLEAR_ON_RESET`=1).
  - `RESET` → `READY` directly at that edge (`CLEAR_ON_RESET`=0).
  - `CLEAR` → `READY` after the clear counter writes address `RAM_DEPTH-1`.
- Clear engine:
  - An ADDR_WIDTH counter starts at 0 and writes all-zero words, one address per cycle.
  - It runs exactly `RAM_DEPTH` cycles.
  - The terminal count is detected explicitly; the counter never wraps.
- While `ready`=0:
  - `writeEn` and `read` are ignored; no array change from the user port.
  - `Dvalid` stays 0.
- Write (`ready`=1, `writeEn`=1): each byte lane k with `byteEn[k]`=1 is updated from `Din`; the other lanes keep their old contents. `byteEn`=0 means no change.
- Read (`ready`=1, `read`=1): the word at `raddr` goes to `Dout` and `Dvalid` pulses.
- Read and write to different addresses in the same cycle are fully independent.
- Same-address read and write in the same cycle:
  - `RDW_MODE`=0 returns the pre-write word.
  - `RDW_MODE`=1 returns the post-write merged word: enabled lanes from `Din`, the rest old.
- Reset asserted at any time (including mid-clear or mid-read pipeline):
  - `Dout`, `Dvalid`, the output register and `ready` clear immediately.
  - The clear counter returns to 0.
  - Array contents are not guaranteed.
  - After release, a full clear restarts from address 0.

## Timing
- Reset values: `Dout`=0, `Dvalid`=0, `ready`=0, clear counter=0.
- Clear timing: `ready` rises at the edge that writes address `RAM_DEPTH-1`. The first user access is accepted at the next edge, `RAM_DEPTH` edges after the first post-reset edge.
- Read latency, for a read sampled at edge N:
  - `OUT_REG`=0: `Dout`/`Dvalid` update at edge N.
  - `OUT_REG`=1: they update at edge N+1.
- Back-to-back reads sustain one word per cycle in both latency modes. `Dvalid` stays high continuously.
- Write latency: a write at edge N is visible to a read sampled at edge N+1. It is visible at edge N only with `RDW_MODE`=1 and the same address.

## Test plan
Configuration `DATA_WIDTH`=32, `ADDR_WIDTH`=4 (depth 16) unless stated.
1. Clear and ready:
   - Stimulus: hold `rst_n`=0 for 3 cycles, then release.
   - Response: `ready`=0 for 16 edges, then 1. Reading addresses 0–15 returns 0x0 each, with one `Dvalid` pulse per read.
2. Write/read sweep:
   - Stimulus: write 2i+1 to address i with `byteEn`=4'hF, then read addresses 0–15 back-to-back.
   - Response: `Dout`=2i+1, `Dvalid` continuously high. Data appears 1 edge after the request with `OUT_REG`=0 and 2 edges after with `OUT_REG`=1.
3. Byte enables:
   - Stimulus: write 32'hAABBCCDD to address 3 with `byteEn`=4'hF, then 32'h11223344 with `byteEn`=4'b0101, then read address 3.
   - Response: 32'hAA22CC44.
4. Read-during-write:
   - Stimulus: address 5 holds 32'h0000000B; in the same cycle, write 32'h12345678 (`byteEn`=4'hF) and read address 5.
   - Response: 32'h0000000B with `RDW_MODE`=0; 32'h12345678 with `RDW_MODE`=1. The next read returns 32'h12345678 in both modes.
5. Reset mid-clear:
   - Stimulus: assert `rst_n`=0 at clear cycle 8, then release.
   - Response: `Dout`/`Dvalid`/`ready` are 0 immediately. A full 16-cycle clear runs again, and every address reads 0.
6. Access while not ready:
   - Stimulus: during clear, write 32'hFFFFFFFF to address 2 and pulse `read`.
   - Response: `Dvalid` stays 0. After `ready`, address 2 reads 0.
